// File: rtl/traffic_monitor_pkg.sv
// Shared types for the traffic-light monitor: lamp codes, error causes, FSM states
// and the transition legality rule used by the tracker.
package traffic_monitor_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'b00,
      GREEN  = 2'b01,
      YELLOW = 2'b10,
      RED    = 2'b11
   } code_e;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'b000,
      ERR_MULTI = 3'b001,
      ERR_TRANS = 3'b010,
      ERR_DWELL = 3'b011
   } err_e;

   typedef enum logic [1:0] {
      ST_INIT  = 2'b00,
      ST_TRACK = 2'b01,
      ST_FAULT = 2'b10
   } fsm_e;

   // Normal mode follows the G->Y->R->G rotation; alert mode only ever heads to
   // yellow, or blinks between yellow and dark.
   function automatic logic trans_legal(input code_e cur, input code_e nxt, input logic alert);
      logic ok;
      ok = 1'b0;
      if (cur == nxt) begin
         ok = 1'b1;
      end else if (!alert) begin
         ok = (cur == GREEN  && nxt == YELLOW) ||
              (cur == YELLOW && nxt == RED)    ||
              (cur == RED    && nxt == GREEN);
      end else begin
         ok = (cur == OFF    && nxt == YELLOW) ||
              (cur == YELLOW && nxt == OFF)    ||
              (cur == GREEN  && nxt == YELLOW) ||
              (cur == RED    && nxt == YELLOW);
      end
      return ok;
   endfunction

endpackage

// File: rtl/traffic_monitor_lamp_decode.sv
// Combinational lamp-pattern decoder; flags any pattern with more than one lamp lit.
// Zero latency.
module lamp_decode
   import traffic_monitor_pkg::*;
(
   input  logic [2:0] lamp_i,
   output code_e      code_o,
   output logic       multi_o
);

   always_comb begin
      code_o  = OFF;
      multi_o = 1'b0;
      case (lamp_i)
         3'b000:  code_o = OFF;
         3'b001:  code_o = GREEN;
         3'b010:  code_o = YELLOW;
         3'b100:  code_o = RED;
         default: multi_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/traffic_monitor.sv
// Traffic-light sequence monitor: decodes sampled lamps, checks transitions and dwell,
// counts rotations, latches the first error. One-cycle latency from sample to outputs.
module traffic_monitor
   import traffic_monitor_pkg::*;
#(
   parameter int MAX_DWELL = 200,
   parameter int CW        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sample,
   input  logic [2:0]    lamp,
   input  logic          alert,
   output logic [1:0]    state_code,
   output logic          valid,
   output logic          err,
   output logic [2:0]    err_code,
   output logic [CW-1:0] dwell,
   output logic [CW-1:0] cycles
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   fsm_e          state_q;
   code_e         code_q;
   logic          valid_q;
   logic          err_q;
   err_e          err_code_q;
   logic [CW-1:0] dwell_q;
   logic [CW-1:0] cycles_q;

   code_e         dec_code;
   logic          dec_multi;
   logic [CW-1:0] dwell_inc;
   logic          dwell_over;

   lamp_decode u_lamp_decode (
      .lamp_i  (lamp),
      .code_o  (dec_code),
      .multi_o (dec_multi)
   );

   assign dwell_inc  = (dwell_q == '1) ? dwell_q : dwell_q + ONE;
   // Overflow is judged on the unsaturated count so a limit at the counter ceiling still trips.
   assign dwell_over = (32'(dwell_q) + 32'd1) > 32'(MAX_DWELL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         code_q     <= OFF;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         dwell_q    <= '0;
         cycles_q   <= '0;
      end else if (sample) begin
         case (state_q)
            ST_INIT: begin
               if (dec_multi) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_MULTI;
                  state_q    <= ST_FAULT;
               end else begin
                  code_q  <= dec_code;
                  valid_q <= 1'b1;
                  dwell_q <= ONE;
                  state_q <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (dec_multi) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_MULTI;
                  state_q    <= ST_FAULT;
               end else if (dec_code == code_q) begin
                  dwell_q <= dwell_inc;
                  if (dwell_over) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_DWELL;
                     state_q    <= ST_FAULT;
                  end
               end else if (trans_legal(code_q, dec_code, alert)) begin
                  code_q  <= dec_code;
                  dwell_q <= ONE;
                  if (code_q == RED && dec_code == GREEN && !alert)
                     cycles_q <= cycles_q + ONE;
               end else begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_TRANS;
                  state_q    <= ST_FAULT;
               end
            end
            ST_FAULT: begin
               // Keep following the lamps for diagnosis; no new errors, rotations frozen.
               if (!dec_multi) begin
                  valid_q <= 1'b1;
                  if (!valid_q || dec_code != code_q) begin
                     code_q  <= dec_code;
                     dwell_q <= ONE;
                  end else begin
                     dwell_q <= dwell_inc;
                  end
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign state_code = code_q;
   assign valid      = valid_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign dwell      = dwell_q;
   assign cycles     = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: directed sequences plus random lamp traffic
// checked against a behavioural model of the monitoring rules.
module tb_traffic_monitor;
   import traffic_monitor_pkg::*;

   localparam int MD  = 3;
   localparam int CWT = 4;
   localparam int SAT = (1 << CWT) - 1;

   localparam logic [2:0] L_OFF = 3'b000;
   localparam logic [2:0] L_G   = 3'b001;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_R   = 3'b100;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           sample = 1'b0;
   logic [2:0]     lamp = 3'b000;
   logic           alert = 1'b0;
   logic [1:0]     state_code;
   logic           valid;
   logic           err;
   logic [2:0]     err_code;
   logic [CWT-1:0] dwell;
   logic [CWT-1:0] cycles;

   traffic_monitor #(.MAX_DWELL(MD), .CW(CWT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (sample),
      .lamp       (lamp),
      .alert      (alert),
      .state_code (state_code),
      .valid      (valid),
      .err        (err),
      .err_code   (err_code),
      .dwell      (dwell),
      .cycles     (cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      fsm_e fsm;
      int   code;
      bit   valid;
      bit   err;
      int   ecode;
      int   dwell;
      int   cycles;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   int   n_vec = 0;
   int   n_cmp = 0;
   int   miscompares = 0;

   function automatic bit rule_ok(int c, int n, bit a);
      if (c == n) return 1'b1;
      if (!a) return (c != 0) && (n != 0) && (n == (c % 3) + 1);
      return (n == 2) || (c == 2 && n == 0);
   endfunction

   function automatic int lamp_to_code(logic [2:0] l);
      if (l == L_OFF) return 0;
      if (l == L_G)   return 1;
      if (l == L_Y)   return 2;
      return 3;
   endfunction

   function automatic logic [2:0] code_to_lamp(int c);
      logic [2:0] tbl [4];
      tbl[0] = L_OFF; tbl[1] = L_G; tbl[2] = L_Y; tbl[3] = L_R;
      return tbl[c];
   endfunction

   function automatic int sat_inc(int d);
      return (d >= SAT) ? SAT : d + 1;
   endfunction

   task automatic model_fault(int code);
      m.err   = 1'b1;
      m.ecode = code;
      m.fsm   = ST_FAULT;
   endtask

   task automatic model_step(bit rst, bit smp, logic [2:0] l, bit a);
      bit one_lamp;
      int n;
      one_lamp = ($countones(l) <= 1);
      n        = lamp_to_code(l);
      if (rst) begin
         m.fsm = ST_INIT; m.code = 0; m.valid = 0; m.err = 0;
         m.ecode = 0; m.dwell = 0; m.cycles = 0;
      end else if (smp) begin
         if (m.fsm == ST_INIT) begin
            if (!one_lamp) model_fault(1);
            else begin
               m.code = n; m.valid = 1; m.dwell = 1; m.fsm = ST_TRACK;
            end
         end else if (m.fsm == ST_TRACK) begin
            if (!one_lamp) model_fault(1);
            else if (n == m.code) begin
               if (m.dwell + 1 > MD) model_fault(3);
               m.dwell = sat_inc(m.dwell);
            end else if (rule_ok(m.code, n, a)) begin
               if (m.code == 3 && n == 1 && !a) m.cycles = (m.cycles + 1) % (SAT + 1);
               m.code = n; m.dwell = 1;
            end else model_fault(2);
         end else if (one_lamp) begin
            if (!m.valid || n != m.code) begin
               m.code = n; m.dwell = 1;
            end else m.dwell = sat_inc(m.dwell);
            m.valid = 1;
         end
      end
   endtask

   task automatic apply(bit rst, bit smp, logic [2:0] l, bit a);
      @(negedge clk);
      rst_n  = !rst;
      sample = smp;
      lamp   = l;
      alert  = a;
      model_step(rst, smp, l, a);
      exp_q.push_back(m);
   endtask

   task automatic seq(logic [2:0] l, bit a);
      apply(1'b0, 1'b1, l, a);
   endtask

   task automatic do_reset();
      apply(1'b1, 1'b0, L_OFF, 1'b0);
   endtask

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
      end
   endtask

   // Monitor: every applied cycle yields one expected snapshot, seen one edge later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk("fsm",        int'(dut.state_q), int'(e.fsm));
            chk("state_code", int'(state_code),  e.code);
            chk("valid",      int'(valid),       int'(e.valid));
            chk("err",        int'(err),         int'(e.err));
            chk("err_code",   int'(err_code),    e.ecode);
            chk("dwell",      int'(dwell),       e.dwell);
            chk("cycles",     int'(cycles),      e.cycles);
         end
      end
   end

   initial begin
      bit         alt;
      int         r;
      logic [2:0] l;
      m = '{fsm: ST_INIT, code: 0, valid: 0, err: 0, ecode: 0, dwell: 0, cycles: 0};

      do_reset(); do_reset();
      // basic rotation
      seq(L_G, 0); seq(L_G, 0); seq(L_Y, 0); seq(L_R, 0); seq(L_G, 0);
      // multi-lamp fault, then tracking continues in FAULT without counting rotations
      do_reset(); seq(L_G, 0); seq(3'b101, 0); seq(L_G, 0); seq(L_Y, 0); seq(L_R, 0); seq(L_G, 0);
      // alert blink
      do_reset(); seq(L_Y, 1); seq(L_OFF, 1); seq(L_Y, 1); seq(L_OFF, 1);
      // illegal transition
      do_reset(); seq(L_G, 0); seq(L_R, 0); seq(3'b111, 0);
      // dwell overflow, then saturation while in FAULT
      do_reset();
      for (int i = 0; i < 20; i++) seq(L_G, 0);
      // reset beats a coincident bad sample
      seq(L_R, 0); apply(1'b1, 1'b1, 3'b111, 1'b0); apply(1'b0, 1'b0, L_OFF, 1'b0);
      // illegal pattern as first sample, then recovery of valid in FAULT
      do_reset(); seq(3'b011, 0); seq(L_OFF, 0); seq(L_OFF, 0);
      // idle cycles with garbage lamps change nothing
      do_reset(); seq(L_Y, 0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 3'b111, 1'b1);
      seq(L_R, 0);
      // rotation counter wrap
      do_reset(); seq(L_G, 0);
      for (int i = 0; i < SAT + 2; i++) begin
         seq(L_Y, 0); seq(L_R, 0); seq(L_G, 0);
      end

      do_reset();
      alt = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) alt = !alt;
         r = $urandom_range(0, 15);
         if (r < 6)       l = code_to_lamp(m.code);
         else if (r < 11) l = code_to_lamp(alt ? ((m.code == 2) ? 0 : 2) : ((m.code % 3) + 1));
         else if (r < 15) l = code_to_lamp($urandom_range(0, 3));
         else             l = 3'($urandom_range(0, 7));
         apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, l, alt);
      end

      @(posedge clk);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected outputs never observed, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule
